// File: rtl/ub_pkg.sv
// Shared definitions for the unified-buffer layer: advance-mode codes,
// the default word type and the address-width helper.
package ub_pkg;

  localparam int UB_ADV_ON_WEN = 0;
  localparam int UB_ADV_ALWAYS = 1;

  typedef logic [15:0] ub_word_t;

  function automatic int ub_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ub_tap_ram.sv
// One-write / NUM_TAPS-read RAM with registered read ports.
// A read and a write to the same slot on one edge return the old word.
module ub_tap_ram
  import ub_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 64,
  parameter int NUM_TAPS = 2,
  localparam int AW      = ub_addr_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_TAPS-1:0]        re,
  input  logic [NUM_TAPS*AW-1:0]     raddr,
  output logic [NUM_TAPS*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic [NUM_TAPS*DATA_W-1:0] rdata_q;
  logic [NUM_TAPS*DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (re[i]) begin
        rdata_d[i*DATA_W +: DATA_W] = mem_q[raddr[i*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Storage is never cleared: flush and reset only restart the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ub_multitap_delay.sv
// Circular delay buffer with NUM_TAPS read taps at fixed delays; owns the
// write pointer, fill tracking, per-tap accept logic and flush/reset priority.
module ub_multitap_delay
  import ub_pkg::*;
#(
  parameter int                    DATA_W       = 16,
  parameter int                    DEPTH        = 64,
  parameter int                    NUM_TAPS     = 2,
  parameter logic [NUM_TAPS*16-1:0] TAP_DELAY   = {16'd4, 16'd1},
  parameter int                    ADVANCE_MODE = UB_ADV_ON_WEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wen,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_TAPS-1:0]        ren,
  output logic [NUM_TAPS*DATA_W-1:0] rdata,
  output logic [NUM_TAPS-1:0]        rvalid,
  output logic [NUM_TAPS-1:0]        underflow,
  output logic [$clog2(DEPTH):0]     fill_count
);

  localparam int AW = ub_addr_w(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_C = FW'(DEPTH);

  logic                   adv;
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [NUM_TAPS-1:0]    rvalid_q, rvalid_d;
  logic [NUM_TAPS-1:0]    underflow_q, underflow_d;
  logic [NUM_TAPS-1:0]    accept, reject;
  logic [NUM_TAPS*AW-1:0] raddr;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ub_multitap_delay: DEPTH must be a power of two >= 2");
  end
  if ((ADVANCE_MODE != UB_ADV_ON_WEN) && (ADVANCE_MODE != UB_ADV_ALWAYS)) begin : g_bad_mode
    $error("ub_multitap_delay: ADVANCE_MODE must be 0 or 1");
  end

  assign adv = ((ADVANCE_MODE == UB_ADV_ALWAYS) ? 1'b1 : wen) && !rst && !flush;

  // A delay of DEPTH truncates to zero in the address, landing on the slot
  // about to be overwritten, which read-before-write turns into the oldest word.
  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    localparam logic [FW-1:0] DLY   = TAP_DELAY[i*16 +: FW];
    localparam logic [AW-1:0] DLY_A = TAP_DELAY[i*16 +: AW];

    if ((int'(TAP_DELAY[i*16 +: 16]) == 0) || (int'(TAP_DELAY[i*16 +: 16]) > DEPTH)) begin : g_bad_delay
      $error("ub_multitap_delay: TAP_DELAY entry out of range 1..DEPTH");
    end

    assign raddr[i*AW +: AW] = wptr_q - DLY_A;
    assign accept[i] = ren[i] && (fill_q >= DLY) && !rst && !flush;
    assign reject[i] = ren[i] && (fill_q < DLY) && !rst && !flush;
  end

  always_comb begin
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    rvalid_d    = accept;
    underflow_d = reject;
    if (flush) begin
      wptr_d = '0;
      fill_d = '0;
    end else if (adv) begin
      wptr_d = wptr_q + 1'b1;
      if (fill_q != DEPTH_C) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      fill_q      <= '0;
      rvalid_q    <= '0;
      underflow_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      rvalid_q    <= rvalid_d;
      underflow_q <= underflow_d;
    end
  end

  ub_tap_ram #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .NUM_TAPS(NUM_TAPS)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (adv),
    .waddr(wptr_q),
    .wdata(wdata),
    .re   (accept),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign rvalid     = rvalid_q;
  assign underflow  = underflow_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_ub_multitap_delay.sv
// Bench for ub_multitap_delay: a mode-0 three-tap instance and a mode-1
// single-tap instance, each checked every cycle against a queue-based model.
module tb_ub_multitap_delay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: DEPTH 8, advance on wen, taps at delays 1, 4, 8.
  logic        rst, flush, wen;
  logic [15:0] wdata;
  logic [2:0]  ren;
  logic [47:0] rdata;
  logic [2:0]  rvalid, underflow;
  logic [3:0]  fill_count;

  // Instance 1: DEPTH 8, advance every cycle, one tap at delay 3.
  logic        rst1, flush1, wen1;
  logic [15:0] wdata1;
  logic        ren1;
  logic [15:0] rdata1;
  logic        rvalid1, underflow1;
  logic [3:0]  fill1;

  ub_multitap_delay #(
    .DATA_W(16), .DEPTH(8), .NUM_TAPS(3),
    .TAP_DELAY({16'd8, 16'd4, 16'd1}), .ADVANCE_MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .underflow(underflow), .fill_count(fill_count)
  );

  ub_multitap_delay #(
    .DATA_W(16), .DEPTH(8), .NUM_TAPS(1),
    .TAP_DELAY(16'd3), .ADVANCE_MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .wen(wen1), .wdata(wdata1), .ren(ren1),
    .rdata(rdata1), .rvalid(rvalid1), .underflow(underflow1), .fill_count(fill1)
  );

  int checks = 0;
  int errors = 0;

  // Model state: history of written words (newest at the back) and fill level.
  int          dly0 [3] = '{1, 4, 8};
  logic [15:0] hist0 [$];
  logic [15:0] hist1 [$];
  int          fill_m0 = 0;
  int          fill_m1 = 0;
  logic [15:0] e_rd0 [3] = '{16'd0, 16'd0, 16'd0};
  logic        e_rv0 [3] = '{1'b0, 1'b0, 1'b0};
  logic        e_uf0 [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] e_rd1 = '0;
  logic        e_rv1 = 1'b0;
  logic        e_uf1 = 1'b0;
  bit          armed = 1'b0;
  int          ramp = 0;

  task automatic checkOutput(input string name, input int tap,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s tap%0d got %0d expected %0d at %0t", name, tap, act, exp, $time);
    end
  endtask

  // Drives one cycle at a negedge, advances the model, returns at the next negedge.
  task automatic applyStimulus(input logic r, input logic f, input logic w,
                               input logic [15:0] wd, input logic [2:0] rn);
    rst = r; flush = f; wen = w; wdata = wd; ren = rn;
    rst1 = r; flush1 = f; wen1 = 1'($urandom_range(0, 1));
    wdata1 = 16'(ramp); ren1 = 1'b1;

    for (int i = 0; i < 3; i++) begin
      e_rv0[i] = 1'b0;
      e_uf0[i] = 1'b0;
      if (r) e_rd0[i] = '0;
      else if (!f && rn[i]) begin
        if (fill_m0 >= dly0[i]) begin
          e_rd0[i] = hist0[hist0.size() - dly0[i]];
          e_rv0[i] = 1'b1;
        end else begin
          e_uf0[i] = 1'b1;
        end
      end
    end
    if (r || f) fill_m0 = 0;
    else if (w) begin
      hist0.push_back(wd);
      if (hist0.size() > 8) void'(hist0.pop_front());
      if (fill_m0 < 8) fill_m0++;
    end

    e_rv1 = 1'b0;
    e_uf1 = 1'b0;
    if (r) e_rd1 = '0;
    else if (!f) begin
      if (fill_m1 >= 3) begin
        e_rd1 = hist1[hist1.size() - 3];
        e_rv1 = 1'b1;
      end else begin
        e_uf1 = 1'b1;
      end
    end
    if (r || f) fill_m1 = 0;
    else begin
      hist1.push_back(wdata1);
      if (hist1.size() > 8) void'(hist1.pop_front());
      if (fill_m1 < 8) fill_m1++;
    end
    ramp = (r || f) ? 0 : ramp + 1;

    armed = 1'b1;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("rdata", i, 32'(rdata[i*16 +: 16]), 32'(e_rd0[i]));
        checkOutput("rvalid", i, 32'(rvalid[i]), 32'(e_rv0[i]));
        checkOutput("underflow", i, 32'(underflow[i]), 32'(e_uf0[i]));
      end
      checkOutput("fill_count", 0, 32'(fill_count), 32'(fill_m0));
      checkOutput("m1_rdata", 0, 32'(rdata1), 32'(e_rd1));
      checkOutput("m1_rvalid", 0, 32'(rvalid1), 32'(e_rv1));
      checkOutput("m1_underflow", 0, 32'(underflow1), 32'(e_uf1));
      checkOutput("m1_fill", 0, 32'(fill1), 32'(fill_m1));
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wen = 1'b0; wdata = '0; ren = '0;
    rst1 = 1'b1; flush1 = 1'b0; wen1 = 1'b0; wdata1 = '0; ren1 = 1'b0;
    @(negedge clk);
    applyStimulus(1, 0, 0, 16'd0, 3'b000);
    applyStimulus(1, 0, 0, 16'd0, 3'b000);
    checkOutput("pin_rst_rdata0", 0, 32'(rdata[15:0]), 32'd0);
    checkOutput("pin_rst_fill", 0, 32'(fill_count), 32'd0);

    // Writes 1..10 with taps 0 and 1 reading; mode-1 ramp runs alongside.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 0, 1, 16'(k), 3'b011);
      if (k == 1) checkOutput("pin_first_uf0", 0, 32'(underflow[0]), 32'd1);
      if (k == 2) checkOutput("pin_first_rd0", 0, 32'(rdata[15:0]), 32'd1);
      if (k == 4) checkOutput("pin_tap1_early", 1, 32'(rvalid[1]), 32'd0);
      if (k == 5) checkOutput("pin_tap1_first", 1, 32'(rdata[31:16]), 32'd1);
      if (k == 3) checkOutput("pin_m1_uf", 0, 32'(underflow1), 32'd1);
      if (k == 4) checkOutput("pin_m1_first", 0, 32'(rdata1), 32'd0);
      if (k == 7) checkOutput("pin_m1_ramp", 0, 32'(rdata1), 32'd3);
    end
    applyStimulus(0, 0, 0, 16'd0, 3'b011);
    checkOutput("pin_after10_tap0", 0, 32'(rdata[15:0]), 32'd10);
    checkOutput("pin_after10_tap1", 1, 32'(rdata[31:16]), 32'd7);

    // Underflow on tap 1 at fill 3.
    applyStimulus(0, 1, 0, 16'd0, 3'b000);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 16'(21 + k), 3'b000);
    applyStimulus(0, 0, 0, 16'd0, 3'b010);
    checkOutput("pin_uf_pulse", 1, 32'(underflow), 32'b010);
    checkOutput("pin_uf_rvalid", 1, 32'(rvalid), 32'd0);
    checkOutput("pin_uf_hold", 1, 32'(rdata[31:16]), 32'd7);
    applyStimulus(0, 0, 0, 16'd0, 3'b000);
    checkOutput("pin_uf_clear", 1, 32'(underflow), 32'd0);

    // Delay equal to DEPTH with concurrent write returns the oldest word.
    applyStimulus(0, 1, 0, 16'd0, 3'b000);
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 1, 16'(100 + k), 3'b000);
    applyStimulus(0, 0, 1, 16'd112, 3'b100);
    checkOutput("pin_oldest", 2, 32'(rdata[47:32]), 32'd104);
    checkOutput("pin_sat_fill", 2, 32'(fill_count), 32'd8);

    // Flush colliding with wen and ren.
    applyStimulus(0, 1, 0, 16'd0, 3'b000);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 1, 16'(200 + k), 3'b000);
    applyStimulus(0, 0, 0, 16'd0, 3'b001);
    applyStimulus(0, 1, 1, 16'd999, 3'b111);
    checkOutput("pin_flush_fill", 0, 32'(fill_count), 32'd0);
    checkOutput("pin_flush_rvalid", 0, 32'(rvalid), 32'd0);
    checkOutput("pin_flush_rd0", 0, 32'(rdata[15:0]), 32'd204);
    checkOutput("pin_flush_rd2", 2, 32'(rdata[47:32]), 32'd104);
    applyStimulus(0, 0, 0, 16'd0, 3'b001);
    checkOutput("pin_flush_uf", 0, 32'(underflow), 32'b001);

    // Reset mid-stream, then refill.
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 16'(40 + k), 3'b011);
    applyStimulus(1, 0, 1, 16'd55, 3'b111);
    checkOutput("pin_rst_rd0", 0, 32'(rdata[15:0]), 32'd0);
    checkOutput("pin_rst_rd2", 2, 32'(rdata[47:32]), 32'd0);
    checkOutput("pin_rst_flags", 0, 32'({rvalid, underflow, fill_count}), 32'd0);
    applyStimulus(0, 0, 1, 16'd1, 3'b001);
    applyStimulus(0, 0, 1, 16'd2, 3'b001);
    checkOutput("pin_refill_rd0", 0, 32'(rdata[15:0]), 32'd1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ub_multitap_delay.md
# ub_multitap_delay

Parametrised multi-tap delay buffer for the unified-buffer layer. It generalises the single-slot stencil-to-stencil shift register into a circular buffer of configurable depth, with `NUM_TAPS` independent read taps, each at its own fixed delay. Fill tracking gates each tap's valid, and `flush` restarts the buffer between frames. It sits between a producer op's write port and one or more consumer op read ports inside a `*_ub` wrapper.

## Interface
- `DATA_W`, 16: word width.
- `DEPTH`, 64: buffer slots; power of two, ≥ 2.
- `NUM_TAPS`, 2: number of read taps, ≥ 1.
- `TAP_DELAY`, {16'd4, 16'd1}: packed `NUM_TAPS`×16 array. Entry i is the delay of tap i in advances, range 1..`DEPTH`.
- `ADVANCE_MODE`, 0: 0 = advance only on `wen`; 1 = advance every cycle (`wen` ignored).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `flush` in 1: synchronous restart, active-high.
- `wen` in 1: write enable; an advance in mode 0.
- `wdata` in `DATA_W`: write word.
- `ren` in `NUM_TAPS`: per-tap read request.
- `rdata` out `NUM_TAPS*DATA_W`: per-tap registered read data; tap i occupies bits [i*`DATA_W` +: `DATA_W`].
- `rvalid` out `NUM_TAPS`: per-tap valid, one cycle after an accepted `ren`.
- `underflow` out `NUM_TAPS`: per-tap one-cycle pulse for a `ren` rejected because the buffer is not filled deep enough.
- `fill_count` out `$clog2(DEPTH)+1`: advances since reset/flush, saturating at `DEPTH`.

## Operation
- Advance event A: `ADVANCE_MODE` ? 1 : `wen`. A is forced to 0 while `rst` or `flush` is high.
- On A:
  - `mem[wptr]` <= `wdata`.
  - `wptr` <= (`wptr`+1) mod `DEPTH`.
  - `fill_count` <= min(`fill_count`+1, `DEPTH`).
- Tap i address: (`wptr` − `TAP_DELAY[i]`) mod `DEPTH`, computed with `wptr` before the edge. This is the word written exactly `TAP_DELAY[i]` advances ago.
- Tap i accepted when `ren[i]` && `fill_count` ≥ `TAP_DELAY[i]`. On acceptance:
  - next edge: `rdata[i]` <= `mem[addr_i]`;
  - `rvalid[i]` <= 1.
- Tap i rejected when `ren[i]` && `fill_count` < `TAP_DELAY[i]`:
  - `underflow[i]` <= 1;
  - `rvalid[i]` <= 0;
  - `rdata[i]` holds.
- No `ren[i]`: `rvalid[i]` <= 0, `underflow[i]` <= 0, `rdata[i]` holds.
- Read-before-write: a read and a write to the same slot on the same edge return the old contents. This case arises when `TAP_DELAY[i]` = `DEPTH`, and that tap then returns the oldest word.
- Taps are fully independent. Any subset of `ren` may be high together with an advance.
- `flush`:
  - `wptr` <= 0, `fill_count` <= 0, `rvalid` <= 0, `underflow` <= 0.
  - Memory contents and `rdata` are retained.
  - Takes priority over `wen` and `ren` in the same cycle: no write, no read, no underflow.
- `rst`: same as `flush`, plus `rdata` <= 0. Highest priority, and it may assert mid-stream.
- `fill_count` saturates at `DEPTH` and never wraps. `wptr` wraps modulo `DEPTH`.
- Elaboration checks (`$error`):
  - `DEPTH` not a power of two;
  - any `TAP_DELAY[i]` equal to 0 or greater than `DEPTH`;
  - `ADVANCE_MODE` not 0 or 1.

## Timing
- Reset values: `rdata` = 0, `rvalid` = 0, `underflow` = 0, `fill_count` = 0; internal `wptr` = 0.
- Read latency is 1 cycle, ren → `rdata`/`rvalid`. There is no combinational path from `ren` or `wdata` to any output.
- Mode 1: a word written at cycle t is addressable by tap i from cycle t+`TAP_DELAY[i]`, and appears on `rdata` at t+`TAP_DELAY[i]`+1.
- `fill_count` updates on the same edge as the write. A `ren` in the cycle after the D-th advance is accepted.
- No ready/stall: the producer writes blindly and overwrite is by design. Consumers must not request reads before `fill_count` reaches their tap's delay.

## Structure
- Shared package `ub_pkg`:
  - `ub_addr_w(depth)` function returning `$clog2(depth)`;
  - `UB_ADV_ON_WEN` = 0 and `UB_ADV_ALWAYS` = 1 constants;
  - `ub_word_t` typedef for the default 16-bit word.
- One sub-module, `ub_tap_ram`: a 1-write / `NUM_TAPS`-read registered RAM with read-before-write semantics.
- The top level owns `wptr`, `fill_count`, the accept logic and flush/reset priority.

## Test plan
- Mode 0, `DEPTH`=8, `TAP_DELAY`={4,1}, write 1..10 with `ren`=2'b11 held high:
  - tap0 `rvalid` from the cycle after the 1st write; tap1 from the cycle after the 4th write;
  - after the write of 10, tap0 returns 10 and tap1 returns 7.
- `ren[1]` at `fill_count`=3 with D=4 → `underflow[1]` pulses 1 cycle, `rvalid[1]`=0, `rdata[1]` holds.
- `TAP_DELAY[0]`=`DEPTH`=8, 12 writes of 100..111, read with a concurrent write of 112:
  - returns 104 (oldest; read-before-write);
  - `fill_count` stays at 8.
- Mode 1, D=3, `wdata` ramps 0,1,2,…, `ren` held high: `rdata` equals the cycle's write value minus 3, valid from the 4th cycle.
- `flush` together with `wen` and `ren` after 5 writes:
  - no write;
  - next cycle `fill_count`=0, `rvalid`=0, `rdata` retains its last value;
  - a `ren` the following cycle underflows.
- `rst` asserted mid-stream for 1 cycle → all outputs return to 0 the next cycle; the subsequent refill behaves as from power-on.
